flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter NFLAGS, default 2, number of flag bits (bit 0 = C, bit 1 = Z), legal 1..8.
REQ-002 Parameter DEPTH, default 4, shadow-stack entries for nested interrupts, legal 1..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 FLG_D  input  NFLAGS  new flag values from ALU.
REQ-006 FLG_LD  input  NFLAGS  per-flag load enable.
REQ-007 FLG_SET  input  NFLAGS  per-flag set to 1.
REQ-008 FLG_CLR  input  NFLAGS  per-flag clear to 0.
REQ-009 FLG_LD_SEL  input  1  load source: 0 = FLG_D, 1 = shadow-stack top (restore).
REQ-010 SHAD_PUSH  input  1  save current FLAGS to shadow stack (interrupt entry).
REQ-011 SHAD_POP  input  1  discard shadow-stack top (RETIE).
REQ-012 FLAGS  output  NFLAGS  registered flag state.
REQ-013 SHAD_CNT  output  $clog2(DEPTH+1)  occupied entries.
REQ-014 SHAD_FULL / SHAD_EMPTY  output  1 each  SHAD_CNT == DEPTH / SHAD_CNT == 0, combinational from count.

Function
REQ-015 Per-flag next value SHALL follow priority FLG_CLR > FLG_SET > FLG_LD > hold.
REQ-016 Load source SHALL be FLG_D when FLG_LD_SEL=0, shadow top when FLG_LD_SEL=1; top when empty reads all zeros.
REQ-017 FLAGS SHALL change one cycle after the controlling inputs are sampled; no combinational input-to-FLAGS path.
REQ-018 Push SHALL store FLAGS value present before the edge (pre-update), never the same-cycle new value.
REQ-019 Push when not full SHALL write at index SHAD_CNT and increment SHAD_CNT.
REQ-020 Pop when not empty SHALL decrement SHAD_CNT; same-cycle restore (FLG_LD_SEL=1) uses the pre-pop top.
REQ-021 Push when full SHALL be ignored; stack contents and SHAD_CNT unchanged.
REQ-022 Pop when empty SHALL be ignored; SHAD_CNT stays 0.
REQ-023 Simultaneous push and pop with SHAD_CNT>0 SHALL overwrite top entry with pre-update FLAGS, SHAD_CNT unchanged.
REQ-024 Simultaneous push and pop with SHAD_CNT=0 SHALL act as push only.
REQ-025 Stack entries above SHAD_CNT SHALL not affect any output.

Reset
REQ-026 RST_N low SHALL immediately force FLAGS=0, SHAD_CNT=0 (SHAD_EMPTY=1, SHAD_FULL=0), independent of CLK.
REQ-027 Stack entry storage need not be reset; only SHAD_CNT bounds validity.
REQ-028 Reset assertion mid-push/pop SHALL abort the operation; first edge after RST_N rises operates normally.

Configuration
REQ-029 Macro FLAG_UNIT_STACK_ERR_EN: when defined, ports ERR_CLR (input 1), ERR_OVF (output 1), ERR_UNF (output 1) SHALL exist.
REQ-030 With macro: ERR_OVF sets on push-when-full (REQ-021), ERR_UNF on pop-when-empty (REQ-022), both sticky, cleared by ERR_CLR or reset; set wins over same-cycle ERR_CLR.
REQ-031 Without macro: those three ports and their registers SHALL be absent; REQ-021/022 behaviour unchanged.

Verification
REQ-032 Reset: RST_N=0 mid-cycle with FLAGS=2'b11, SHAD_CNT=2 -> FLAGS=0, SHAD_CNT=0 before next CLK edge.
REQ-033 Priority: FLG_D=2'b11, FLG_LD=2'b11, FLG_SET=2'b00, FLG_CLR=2'b01 -> FLAGS=2'b10 next cycle.
REQ-034 Save/restore: FLAGS=2'b01, push + FLG_LD=2'b11 FLG_D=2'b10 same cycle -> FLAGS=2'b10, entry0=2'b01; later pop + FLG_LD_SEL=1, FLG_LD=2'b11 -> FLAGS=2'b01, SHAD_CNT=0.
REQ-035 Overflow: DEPTH=4, five pushes -> SHAD_CNT=4, SHAD_FULL=1, entries 0..3 intact, ERR_OVF=1 (macro on).
REQ-036 Underflow/simultaneous: pop at SHAD_CNT=0 -> SHAD_CNT=0, ERR_UNF=1; push+pop at SHAD_CNT=2 with FLAGS=2'b11 -> SHAD_CNT=2, top=2'b11.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: processor status-flag register with a shadow stack for nested
// interrupts. Each flag is cleared, set, loaded (from the ALU or from the
// shadow-stack top) or held, with clear having the highest priority.
// Interrupt entry pushes the current flags and RETIE pops them.
// Optional feature: define FLAG_UNIT_STACK_ERR_EN to add sticky overflow and
// underflow error flags (ports i_err_clr, o_err_ovf, o_err_unf).

module flag_unit #(
   parameter int NFLAGS = 2,
   parameter int DEPTH  = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NFLAGS-1:0] i_flg_d,
   input  logic [NFLAGS-1:0] i_flg_ld,
   input  logic [NFLAGS-1:0] i_flg_set,
   input  logic [NFLAGS-1:0] i_flg_clr,
   input  logic              i_flg_ld_sel,
   input  logic              i_shad_push,
   input  logic              i_shad_pop,
`ifdef FLAG_UNIT_STACK_ERR_EN
   input  logic              i_err_clr,
   output logic              o_err_ovf,
   output logic              o_err_unf,
`endif
   output logic [NFLAGS-1:0] o_flags,
   output logic [CW-1:0]     o_shad_cnt,
   output logic              o_shad_full,
   output logic              o_shad_empty
);

   // The storage array is sized to the full range of the count so that the
   // count can index it directly; entries at or above DEPTH are never written.
   localparam int SLOTS = 1 << CW;

   logic [NFLAGS-1:0] r_flags;
   logic [CW-1:0]     r_cnt;
   logic [NFLAGS-1:0] r_stack [SLOTS];

   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_topIdx;
   logic [NFLAGS-1:0] w_top;
   logic [NFLAGS-1:0] w_ldSrc;
   logic [NFLAGS-1:0] w_flagsNext;
   logic              w_swapTop;
   logic              w_pushOk;
   logic              w_popOk;
   logic              w_wrEn;
   logic [CW-1:0]     w_wrIdx;

   assign w_full   = (r_cnt == CW'(DEPTH));
   assign w_empty  = (r_cnt == '0);
   assign w_topIdx = r_cnt - CW'(1);

   // Stack top as seen by a restore; an empty stack restores all zeros so that
   // stale entries never leak out.
   always_comb begin
      w_top = '0;
      if (!w_empty) begin
         w_top = r_stack[w_topIdx];
      end
   end

   assign w_ldSrc = i_flg_ld_sel ? w_top : i_flg_d;

   // Per-flag next value: clear beats set, set beats load, otherwise hold.
   always_comb begin
      w_flagsNext = r_flags;
      for (int i = 0; i < NFLAGS; i++) begin
         if (i_flg_clr[i]) begin
            w_flagsNext[i] = 1'b0;
         end else if (i_flg_set[i]) begin
            w_flagsNext[i] = 1'b1;
         end else if (i_flg_ld[i]) begin
            w_flagsNext[i] = w_ldSrc[i];
         end
      end
   end

   // Push and pop together on a non-empty stack replace the top entry in place;
   // on an empty stack the pop half is dropped and it behaves as a plain push.
   assign w_swapTop = i_shad_push && i_shad_pop && !w_empty;
   assign w_pushOk  = i_shad_push && !w_swapTop && !w_full;
   assign w_popOk   = i_shad_pop && !i_shad_push && !w_empty;
   assign w_wrEn    = w_swapTop || w_pushOk;
   assign w_wrIdx   = w_swapTop ? w_topIdx : r_cnt;

   // Flag register and stack occupancy; reset clears both at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flags <= '0;
         r_cnt   <= '0;
      end else begin
         r_flags <= w_flagsNext;
         if (w_pushOk) begin
            r_cnt <= r_cnt + CW'(1);
         end else if (w_popOk) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Stack entries hold the pre-update flags; they are not reset because the
   // count alone decides which entries are valid.
   always_ff @(posedge i_clk) begin
      if (w_wrEn) begin
         r_stack[w_wrIdx] <= r_flags;
      end
   end

`ifdef FLAG_UNIT_STACK_ERR_EN
   logic r_errOvf;
   logic r_errUnf;
   logic w_ovfEvt;
   logic w_unfEvt;

   assign w_ovfEvt = i_shad_push && !i_shad_pop && w_full;
   assign w_unfEvt = i_shad_pop && !i_shad_push && w_empty;

   // Sticky error flags; a new error in the same cycle as a clear still sets.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_errOvf <= 1'b0;
         r_errUnf <= 1'b0;
      end else begin
         if (w_ovfEvt) begin
            r_errOvf <= 1'b1;
         end else if (i_err_clr) begin
            r_errOvf <= 1'b0;
         end
         if (w_unfEvt) begin
            r_errUnf <= 1'b1;
         end else if (i_err_clr) begin
            r_errUnf <= 1'b0;
         end
      end
   end

   assign o_err_ovf = r_errOvf;
   assign o_err_unf = r_errUnf;
`endif

   assign o_flags      = r_flags;
   assign o_shad_cnt   = r_cnt;
   assign o_shad_full  = w_full;
   assign o_shad_empty = w_empty;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed self-checking bench for flag_unit with default
// parameters (NFLAGS=2, DEPTH=4). Error-flag checks are compiled in only when
// FLAG_UNIT_STACK_ERR_EN is defined.

module tb_flag_unit;

   logic       clk;
   logic       rstN;
   logic [1:0] flgD;
   logic [1:0] flgLd;
   logic [1:0] flgSet;
   logic [1:0] flgClr;
   logic       flgLdSel;
   logic       shadPush;
   logic       shadPop;
   logic [1:0] flags;
   logic [2:0] shadCnt;
   logic       shadFull;
   logic       shadEmpty;
`ifdef FLAG_UNIT_STACK_ERR_EN
   logic       errClr;
   logic       errOvf;
   logic       errUnf;
`endif

   int passCnt  = 0;
   int checkCnt = 0;

   flag_unit #(.NFLAGS(2), .DEPTH(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_flg_d      (flgD),
      .i_flg_ld     (flgLd),
      .i_flg_set    (flgSet),
      .i_flg_clr    (flgClr),
      .i_flg_ld_sel (flgLdSel),
      .i_shad_push  (shadPush),
      .i_shad_pop   (shadPop),
`ifdef FLAG_UNIT_STACK_ERR_EN
      .i_err_clr    (errClr),
      .o_err_ovf    (errOvf),
      .o_err_unf    (errUnf),
`endif
      .o_flags      (flags),
      .o_shad_cnt   (shadCnt),
      .o_shad_full  (shadFull),
      .o_shad_empty (shadEmpty)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Applies one set of control inputs.
   task automatic drive(input logic [1:0] d, input logic [1:0] ld,
                        input logic [1:0] set, input logic [1:0] clr,
                        input logic sel, input logic push, input logic pop);
      flgD     = d;
      flgLd    = ld;
      flgSet   = set;
      flgClr   = clr;
      flgLdSel = sel;
      shadPush = push;
      shadPop  = pop;
   endtask

   // Advances one clock and settles just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      step();
      checkCnt++;
      if (flags !== 2'b00) $display("[TB] FAIL reset_flags got %b want 00", flags); else passCnt++;
      checkCnt++;
      if (shadCnt !== 3'd0 || shadEmpty !== 1'b1 || shadFull !== 1'b0)
         $display("[TB] FAIL reset_cnt got cnt=%0d empty=%b full=%b want 0/1/0", shadCnt, shadEmpty, shadFull);
      else passCnt++;
      rstN = 1'b1;
      step();
      // Build FLAGS=11 with two stacked entries, then reset mid-cycle.
      drive(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      step();
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      checkCnt++;
      if (flags !== 2'b11 || shadCnt !== 3'd2)
         $display("[TB] FAIL pre_reset got flags=%b cnt=%0d want 11/2", flags, shadCnt);
      else passCnt++;
      #3 rstN = 1'b0;
      #1;
      checkCnt++;
      if (flags !== 2'b00 || shadCnt !== 3'd0 || shadEmpty !== 1'b1 || shadFull !== 1'b0)
         $display("[TB] FAIL async_reset got flags=%b cnt=%0d empty=%b want 00/0/1", flags, shadCnt, shadEmpty);
      else passCnt++;
      #2 rstN = 1'b1;
      step();
      checkCnt++;
      if (flags !== 2'b00 || shadCnt !== 3'd0)
         $display("[TB] FAIL post_reset got flags=%b cnt=%0d want 00/0", flags, shadCnt);
      else passCnt++;
   endtask

   task automatic test_priority();
      // Clear beats load on bit 0, load wins on bit 1.
      drive(2'b11, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b10) $display("[TB] FAIL prio_clr_ld got %b want 10", flags); else passCnt++;
      // Set beats load of zero on bit 0; bit 1 loads zero.
      drive(2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b01) $display("[TB] FAIL prio_set_ld got %b want 01", flags); else passCnt++;
      // Clear beats set on bit 1, set on bit 0.
      drive(2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b01) $display("[TB] FAIL prio_clr_set got %b want 01", flags); else passCnt++;
      // No controls: hold even with FLG_D changing.
      drive(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b01) $display("[TB] FAIL hold got %b want 01", flags); else passCnt++;
      // Partial load: only bit 1 loads.
      drive(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b11) $display("[TB] FAIL partial_ld got %b want 11", flags); else passCnt++;
   endtask

   task automatic test_save_restore();
      drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      // Push saves 01 while FLAGS loads 10 in the same cycle.
      drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b10 || shadCnt !== 3'd1 || shadEmpty !== 1'b0)
         $display("[TB] FAIL save got flags=%b cnt=%0d want 10/1", flags, shadCnt);
      else passCnt++;
      drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
      step();
      checkCnt++;
      if (flags !== 2'b01 || shadCnt !== 3'd0 || shadEmpty !== 1'b1)
         $display("[TB] FAIL restore got flags=%b cnt=%0d want 01/0", flags, shadCnt);
      else passCnt++;
      // Restore from an empty stack yields zeros.
      drive(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      step();
      checkCnt++;
      if (flags !== 2'b00) $display("[TB] FAIL empty_restore got %b want 00", flags); else passCnt++;
   endtask

   task automatic test_overflow();
      logic [1:0] expTop [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
      drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      // Entries become 01,10,11,00 while FLAGS walks 10,11,00,01.
      drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); step();
      drive(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); step();
      drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); step();
      drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); step();
      checkCnt++;
      if (shadCnt !== 3'd4 || shadFull !== 1'b1 || flags !== 2'b01)
         $display("[TB] FAIL fill got cnt=%0d full=%b flags=%b want 4/1/01", shadCnt, shadFull, flags);
      else passCnt++;
`ifdef FLAG_UNIT_STACK_ERR_EN
      checkCnt++;
      if (errOvf !== 1'b0) $display("[TB] FAIL ovf_early got %b want 0", errOvf); else passCnt++;
`endif
      // Fifth push is dropped; FLAGS still loads.
      drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      checkCnt++;
      if (shadCnt !== 3'd4 || shadFull !== 1'b1 || flags !== 2'b10)
         $display("[TB] FAIL overflow got cnt=%0d full=%b flags=%b want 4/1/10", shadCnt, shadFull, flags);
      else passCnt++;
`ifdef FLAG_UNIT_STACK_ERR_EN
      checkCnt++;
      if (errOvf !== 1'b1) $display("[TB] FAIL ovf_flag got %b want 1", errOvf); else passCnt++;
`endif
      // Unwind and confirm every entry survived.
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
         step();
         checkCnt++;
         if (flags !== expTop[i] || shadCnt !== 3'(3 - i))
            $display("[TB] FAIL unwind%0d got flags=%b cnt=%0d want %b/%0d", i, flags, shadCnt, expTop[i], 3 - i);
         else passCnt++;
      end
   endtask

   task automatic test_underflow();
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      step();
      checkCnt++;
      if (shadCnt !== 3'd0 || shadEmpty !== 1'b1)
         $display("[TB] FAIL underflow got cnt=%0d empty=%b want 0/1", shadCnt, shadEmpty);
      else passCnt++;
`ifdef FLAG_UNIT_STACK_ERR_EN
      checkCnt++;
      if (errUnf !== 1'b1 || errOvf !== 1'b1)
         $display("[TB] FAIL unf_flag got unf=%b ovf=%b want 1/1", errUnf, errOvf);
      else passCnt++;
      // Clear together with a fresh underflow: set wins for UNF, OVF clears.
      errClr = 1'b1;
      step();
      checkCnt++;
      if (errUnf !== 1'b1 || errOvf !== 1'b0)
         $display("[TB] FAIL clr_vs_set got unf=%b ovf=%b want 1/0", errUnf, errOvf);
      else passCnt++;
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      errClr = 1'b0;
      checkCnt++;
      if (errUnf !== 1'b0) $display("[TB] FAIL unf_clear got %b want 0", errUnf); else passCnt++;
`endif
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      drive(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0); step();
      drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); step();
      drive(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0); step();
      checkCnt++;
      if (shadCnt !== 3'd2 || flags !== 2'b11)
         $display("[TB] FAIL setup2 got cnt=%0d flags=%b want 2/11", shadCnt, flags);
      else passCnt++;
      // Push+pop at count 2: top (was 10) becomes 11, count stays 2.
      drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1); step();
      checkCnt++;
      if (shadCnt !== 3'd2 || flags !== 2'b00)
         $display("[TB] FAIL swap got cnt=%0d flags=%b want 2/00", shadCnt, flags);
      else passCnt++;
      drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1); step();
      checkCnt++;
      if (flags !== 2'b11 || shadCnt !== 3'd1)
         $display("[TB] FAIL swap_top got flags=%b cnt=%0d want 11/1", flags, shadCnt);
      else passCnt++;
      step();
      checkCnt++;
      if (flags !== 2'b01 || shadCnt !== 3'd0)
         $display("[TB] FAIL swap_below got flags=%b cnt=%0d want 01/0", flags, shadCnt);
      else passCnt++;
      // Push+pop on an empty stack acts as a push of the pre-update 01.
      drive(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1); step();
      checkCnt++;
      if (shadCnt !== 3'd1 || flags !== 2'b10)
         $display("[TB] FAIL pushpop_empty got cnt=%0d flags=%b want 1/10", shadCnt, flags);
      else passCnt++;
`ifdef FLAG_UNIT_STACK_ERR_EN
      checkCnt++;
      if (errUnf !== 1'b0) $display("[TB] FAIL pushpop_unf got %b want 0", errUnf); else passCnt++;
`endif
      drive(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1); step();
      checkCnt++;
      if (flags !== 2'b01 || shadCnt !== 3'd0)
         $display("[TB] FAIL pushpop_restore got flags=%b cnt=%0d want 01/0", flags, shadCnt);
      else passCnt++;
   endtask

   // Runs every scenario in order and prints the summary.
   initial begin
      rstN = 1'b0;
`ifdef FLAG_UNIT_STACK_ERR_EN
      errClr = 1'b0;
`endif
      drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_priority();
      test_save_restore();
      test_overflow();
      test_underflow();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
